coin_acceptor: RTL and testbench
================================

# coin_acceptor

Coin front-end for the vending controller. Synchronises and debounces the raw 5- and 10-unit coin sensor lines and turns each clean coin insertion into one coin event. Arbitrates illegal simultaneous insertions and buffers accepted coins in a small queue. Presents queued coins to the vending FSM as `c_5` / `c_10` under a ready handshake, so no coin is lost while the FSM is in IDLE or DISPENSE.

## Interface
- `DEB_CYCLES`, 4: consecutive stable synchronised samples required before a debounced level changes (≥2).
- `QDEPTH`, 4: coin queue depth, power of two (≥2).
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `coin5_raw` input 1: raw 5-unit sensor, asynchronous, bouncy, high while a coin passes.
- `coin10_raw` input 1: raw 10-unit sensor, same properties.
- `coin_ready` input 1: consumer accepts the presented coin at this edge.
- `c_5` output 1: head-of-queue coin is 5 units; held until accepted.
- `c_10` output 1: head-of-queue coin is 10 units; held until accepted.
- `coin_reject` output 1: one-cycle pulse, a coin event was discarded.
- `value_cnt` output 8: running total of accepted value in 5-unit steps, saturating at 255.

## Operation
- Synchroniser: 2-flop per raw input, no logic between flops.
- Debounce FSM per input:
  - States: LO, CHK_HI, HI, CHK_LO.
  - LO→CHK_HI when the synced input is 1.
  - In CHK_HI: the counter increments each cycle the input stays 1; any 0 returns to LO with counter cleared. Reaching DEB_CYCLES goes to HI and raises a one-cycle `rise` event.
  - HI/CHK_LO mirror this for release. Release produces no event.
  - Counter width: clog2(DEB_CYCLES+1).
- Arbitration, per cycle:
  - `rise5` and `rise10` together: both discarded, `coin_reject`=1, nothing queued.
  - Single rise: pushed as COIN_5 or COIN_10.
  - Push when count==QDEPTH and no pop this cycle: discarded, `coin_reject`=1.
  - Push when full with a pop in the same cycle: accepted; count unchanged.
- Queue: QDEPTH×1-bit circular buffer, rd/wr pointers clog2(QDEPTH) bits with natural wrap, separate count of clog2(QDEPTH)+1 bits.
- Output mapping:
  - Non-empty: `c_5` = (head==COIN_5), `c_10` = (head==COIN_10). Never both high.
  - Empty: both 0.
- Pop: occurs when (`c_5`|`c_10`) & `coin_ready`. `coin_ready` while empty is ignored.
- `value_cnt`: +1 on a COIN_5 pop, +2 on a COIN_10 pop, clamped to 255 (254 + COIN_10 → 255).

## Timing
- Reset values:
  - Outputs: `c_5`=0, `c_10`=0, `coin_reject`=0, `value_cnt`=0.
  - Internal: queue empty, pointers 0, both FSMs in LO, counters 0, synchronisers 0.
- Reset asserted mid-operation clears the queue contents and any partial debounce immediately. A raw line already high at deassertion must debounce from LO and produces one event.
- Latency: with the queue empty and the raw line held high, `c_5`/`c_10` is high after edge 3+DEB_CYCLES, counted from the first edge that samples the raw input high (7 edges at default).
- Outputs are registered-state only: decoded from queue registers, with no combinational path from any input.
- `coin_reject` is high exactly one cycle, in the cycle after the discarded rise.
- Back-to-back pops are possible every cycle while the queue is non-empty. A push into an empty queue is visible at the next edge; there is no bypass.

## Structure
- Package `coin_pkg`:
  - COIN_5=1'b0, COIN_10=1'b1.
  - Debounce state encodings LO=2'b00, CHK_HI=2'b01, HI=2'b10, CHK_LO=2'b11.
  - VALUE_MAX=8'd255.
- Sub-module `coin_debounce` (synchroniser + debounce FSM + `rise` output), parameterised by DEB_CYCLES, instantiated twice.
- Top holds arbitration, queue, handshake and value counter.

## Test plan
- Single clean 5 pulse, raw high 10 cycles, `coin_ready`=1 → `c_5` high exactly 1 cycle at edge 7, `value_cnt`=1, no reject.
- Bouncy 10: raw toggles 1,0,1,0 then holds high 8 cycles → exactly one `c_10` event, `value_cnt`=2.
- `coin5_raw` and `coin10_raw` rise on the same edge and held → `coin_reject` one cycle, no `c_5`/`c_10`, `value_cnt` unchanged.
- `coin_ready`=0, insert 5 coins (alternating 5/10, spaced) → 4 queued, 5th gives `coin_reject`. Then `coin_ready`=1 → pops in order 5,10,5,10 on consecutive cycles, `value_cnt`=6.
- Full queue, insertion completes in the same cycle as a pop → accepted, no reject, count stays 4.
- Preload `value_cnt`=254 via 127 COIN_10 pops, then one COIN_10 → 255; another COIN_5 → stays 255. Async reset mid-queue → outputs 0 the same cycle.

Source files
------------

// File: rtl/coin_pkg.sv
// coin_pkg: shared types and constants for the coin acceptor.
//   coin_t       - queued coin denomination (one bit per queue slot)
//   deb_state_t  - debounce FSM state encoding
//   VALUE_MAX    - saturation ceiling of the accepted-value counter
//   value_add()  - saturating add of one coin's value (5-unit steps)
package coin_pkg;

   typedef enum logic {
      COIN_5  = 1'b0,
      COIN_10 = 1'b1
   } coin_t;

   typedef enum logic [1:0] {
      LO     = 2'b00,
      CHK_HI = 2'b01,
      HI     = 2'b10,
      CHK_LO = 2'b11
   } deb_state_t;

   localparam logic [7:0] VALUE_MAX = 8'd255;

   // A 5-unit coin counts one step and a 10-unit coin two steps; the total
   // clamps at VALUE_MAX rather than wrapping.
   function automatic logic [7:0] value_add(input logic [7:0] value, input coin_t coin);
      logic [8:0] sum_s;
      sum_s = {1'b0, value} + ((coin == COIN_10) ? 9'd2 : 9'd1);
      if (sum_s > {1'b0, VALUE_MAX}) begin
         value_add = VALUE_MAX;
      end else begin
         value_add = sum_s[7:0];
      end
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: two-flop synchroniser followed by a debounce FSM for one
// raw coin sensor line.
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   raw   - asynchronous, bouncy sensor level
//   rise  - one-cycle pulse when the debounced level goes high
// The debounced level only changes after DEB_CYCLES consecutive agreeing
// synchronised samples; the sample that leaves LO/HI is the first of them.
module coin_debounce
   import coin_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_r;
   logic             sync2_r;
   deb_state_t       state_r;
   deb_state_t       state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             rise_r;
   logic             rise_s;

   // Synchroniser: plain flop chain, nothing between the stages.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
      end
   end

   // Debounce state, stability counter and registered rise pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= LO;
         cnt_r   <= {CNT_W{1'b0}};
         rise_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         rise_r  <= rise_s;
      end
   end

   // Next-state logic: any disagreeing sample during a check aborts it.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      rise_s  = 1'b0;
      case (state_r)
         LO: begin
            if (sync2_r) begin
               state_s = CHK_HI;
               cnt_s   = CNT_ONE;
            end else begin
               cnt_s   = {CNT_W{1'b0}};
            end
         end
         CHK_HI: begin
            if (!sync2_r) begin
               state_s = LO;
               cnt_s   = {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
               state_s = HI;
               cnt_s   = {CNT_W{1'b0}};
               rise_s  = 1'b1;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         HI: begin
            if (!sync2_r) begin
               state_s = CHK_LO;
               cnt_s   = CNT_ONE;
            end else begin
               cnt_s   = {CNT_W{1'b0}};
            end
         end
         CHK_LO: begin
            if (sync2_r) begin
               state_s = HI;
               cnt_s   = {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
               state_s = LO;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = LO;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   assign rise = rise_r;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: coin front-end for the vending controller.
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   coin5_raw    - raw 5-unit sensor (asynchronous, bouncy)
//   coin10_raw   - raw 10-unit sensor (asynchronous, bouncy)
//   coin_ready   - consumer takes the presented coin at this edge
//   c_5 / c_10   - head-of-queue coin type, held until taken
//   coin_reject  - one-cycle pulse, a coin event was discarded
//   value_cnt    - accepted value in 5-unit steps, saturating at 255
// Both sensors are debounced into rise events, simultaneous rises are
// rejected, and single rises are queued in a QDEPTH-entry FIFO. c_5/c_10
// are decoded purely from queue registers, so no input reaches them
// combinationally and a reset clears them immediately.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int QDEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin5_raw,
   input  logic       coin10_raw,
   input  logic       coin_ready,
   output logic       c_5,
   output logic       c_10,
   output logic       coin_reject,
   output logic [7:0] value_cnt
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic             rise5_s;
   logic             rise10_s;
   coin_t            mem_r [QDEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             reject_r;
   logic [7:0]       value_r;

   logic             push_req_s;
   coin_t            push_coin_s;
   logic             push_s;
   logic             pop_s;
   logic             reject_s;
   logic             head_valid_s;
   coin_t            head_s;

   coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb5 (
      .clk  (clk),
      .rst  (rst),
      .raw  (coin5_raw),
      .rise (rise5_s)
   );

   coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb10 (
      .clk  (clk),
      .rst  (rst),
      .raw  (coin10_raw),
      .rise (rise10_s)
   );

   assign head_valid_s = (count_r != {CNT_W{1'b0}});
   assign head_s       = mem_r[rd_ptr_r];

   // Arbitration and handshake: a push into a full queue is only taken
   // when the head leaves in the same cycle, freeing its slot.
   always_comb begin
      push_req_s  = 1'b0;
      push_coin_s = COIN_5;
      reject_s    = 1'b0;
      if (rise5_s && rise10_s) begin
         reject_s    = 1'b1;
      end else if (rise5_s) begin
         push_req_s  = 1'b1;
         push_coin_s = COIN_5;
      end else if (rise10_s) begin
         push_req_s  = 1'b1;
         push_coin_s = COIN_10;
      end else begin
         push_req_s  = 1'b0;
      end
      pop_s  = head_valid_s && coin_ready;
      push_s = push_req_s && ((count_r != FULL_CNT) || pop_s);
      if (push_req_s && !push_s) begin
         reject_s = 1'b1;
      end else begin
         reject_s = reject_s;
      end
   end

   // Circular coin buffer with separate occupancy count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            mem_r[i] <= COIN_5;
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_coin_s;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Reject pulse and saturating accepted-value total.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reject_r <= 1'b0;
         value_r  <= 8'd0;
      end else begin
         reject_r <= reject_s;
         if (pop_s) begin
            value_r <= value_add(value_r, head_s);
         end
      end
   end

   assign c_5         = head_valid_s && (head_s == COIN_5);
   assign c_10        = head_valid_s && (head_s == COIN_10);
   assign coin_reject = reject_r;
   assign value_cnt   = value_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: table of coin insertions plus
// hand-written sequences for latency, queue-full, saturation and reset.
// Expected coins go into a scoreboard queue when stimulus is driven and are
// popped and compared whenever the DUT hands over a coin.
module tb_coin_acceptor;
   import coin_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       coin5_raw = 1'b0;
   logic       coin10_raw = 1'b0;
   logic       coin_ready = 1'b0;
   logic       c_5;
   logic       c_10;
   logic       coin_reject;
   logic [7:0] value_cnt;

   int   n_vec = 0;
   int   n_err = 0;
   int   rej_seen = 0;
   int   pops_seen = 0;
   logic exp_q[$];

   typedef struct {
      logic c5;
      logic c10;
      int   bounce;
      int   hold;
      logic exp_valid;
      logic exp_coin;
      int   exp_rej;
      int   exp_value;
   } vec_t;

   vec_t vecs[6];

   coin_acceptor #(.DEB_CYCLES(4), .QDEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .coin5_raw   (coin5_raw),
      .coin10_raw  (coin10_raw),
      .coin_ready  (coin_ready),
      .c_5         (c_5),
      .c_10        (c_10),
      .coin_reject (coin_reject),
      .value_cnt   (value_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic insert(input logic c5, input logic c10, input int bounce, input int hold);
      for (int b = 0; b < bounce; b++) begin
         coin5_raw = c5; coin10_raw = c10;
         cyc(1);
         coin5_raw = 1'b0; coin10_raw = 1'b0;
         cyc(1);
      end
      coin5_raw = c5; coin10_raw = c10;
      cyc(hold);
      coin5_raw = 1'b0; coin10_raw = 1'b0;
      cyc(12);
   endtask

   // Scoreboard / monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (coin_reject === 1'b1) rej_seen++;
      if ((c_5 || c_10) && coin_ready) begin
         pops_seen++;
         check("c5_c10_exclusive", {31'd0, c_5 & c_10}, 32'd0);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_coin: got c_5=%0b c_10=%0b, expected no coin", c_5, c_10);
         end else begin
            check("coin_type", {31'd0, c_10}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      int r0;
      int p0;

      vecs[0] = '{c5:1'b0, c10:1'b1, bounce:2, hold:8,  exp_valid:1'b1, exp_coin:COIN_10, exp_rej:0, exp_value:3};
      vecs[1] = '{c5:1'b1, c10:1'b1, bounce:0, hold:10, exp_valid:1'b0, exp_coin:COIN_5,  exp_rej:1, exp_value:3};
      vecs[2] = '{c5:1'b1, c10:1'b0, bounce:1, hold:6,  exp_valid:1'b1, exp_coin:COIN_5,  exp_rej:0, exp_value:4};
      vecs[3] = '{c5:1'b0, c10:1'b1, bounce:0, hold:4,  exp_valid:1'b1, exp_coin:COIN_10, exp_rej:0, exp_value:6};
      vecs[4] = '{c5:1'b1, c10:1'b0, bounce:0, hold:3,  exp_valid:1'b0, exp_coin:COIN_5,  exp_rej:0, exp_value:6};
      vecs[5] = '{c5:1'b1, c10:1'b0, bounce:0, hold:10, exp_valid:1'b1, exp_coin:COIN_5,  exp_rej:0, exp_value:7};

      // Reset state.
      cyc(3);
      check("rst_c_5", {31'd0, c_5}, 32'd0);
      check("rst_c_10", {31'd0, c_10}, 32'd0);
      check("rst_reject", {31'd0, coin_reject}, 32'd0);
      check("rst_value", {24'd0, value_cnt}, 32'd0);
      rst = 1'b1;
      cyc(2);

      // Latency: raw first sampled high at edge 1, coin visible after edge 7.
      coin_ready = 1'b1;
      exp_q.push_back(COIN_5);
      coin5_raw = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("latency_c5_edge%0d", e), {31'd0, c_5}, {31'd0, (e == 7)});
      end
      cyc(1);
      coin5_raw = 1'b0;
      cyc(12);
      check("latency_value", {24'd0, value_cnt}, 32'd1);

      // Table-driven insertions with coin_ready held high.
      for (int v = 0; v < 6; v++) begin
         coin_ready = 1'b1;
         r0 = rej_seen;
         if (vecs[v].exp_valid) exp_q.push_back(vecs[v].exp_coin);
         insert(vecs[v].c5, vecs[v].c10, vecs[v].bounce, vecs[v].hold);
         check($sformatf("vec%0d_reject", v), rej_seen - r0, vecs[v].exp_rej);
         check($sformatf("vec%0d_value", v), {24'd0, value_cnt}, vecs[v].exp_value);
         check($sformatf("vec%0d_sb_empty", v), exp_q.size(), 0);
      end

      // Fill the queue with ready low; the fifth coin is rejected.
      coin_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         r0 = rej_seen;
         if (i < 4) exp_q.push_back(logic'(i % 2));
         insert((i % 2) == 0, (i % 2) == 1, 0, 8);
         check($sformatf("fill%0d_reject", i), rej_seen - r0, (i == 4) ? 1 : 0);
      end
      check("fill_value_held", {24'd0, value_cnt}, 32'd7);
      coin_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("drain_valid%0d", k), {31'd0, c_5 | c_10}, {31'd0, (k < 4)});
      end
      cyc(2);
      check("drain_sb_empty", exp_q.size(), 0);
      check("drain_value", {24'd0, value_cnt}, 32'd13);

      // Full queue, push and pop land on the same edge.
      coin_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(logic'(i % 2));
         insert((i % 2) == 0, (i % 2) == 1, 0, 8);
      end
      r0 = rej_seen;
      exp_q.push_back(COIN_5);
      coin5_raw = 1'b1;
      cyc(6);
      coin_ready = 1'b1;
      cyc(1);
      coin_ready = 1'b0;
      cyc(3);
      coin5_raw = 1'b0;
      cyc(12);
      check("fullpop_reject", rej_seen - r0, 0);
      p0 = pops_seen;
      coin_ready = 1'b1;
      cyc(8);
      check("fullpop_count", pops_seen - p0, 4);
      check("fullpop_sb_empty", exp_q.size(), 0);
      check("fullpop_value", {24'd0, value_cnt}, 32'd20);

      // Saturation: 127 ten-unit coins from zero reach 254.
      rst = 1'b0;
      cyc(2);
      rst = 1'b1;
      exp_q.delete();
      coin_ready = 1'b1;
      for (int i = 0; i < 127; i++) begin
         exp_q.push_back(COIN_10);
         insert(1'b0, 1'b1, 0, 6);
      end
      check("sat_preload", {24'd0, value_cnt}, 32'd254);
      exp_q.push_back(COIN_10);
      insert(1'b0, 1'b1, 0, 6);
      check("sat_254_plus_10", {24'd0, value_cnt}, 32'd255);
      exp_q.push_back(COIN_5);
      insert(1'b1, 1'b0, 0, 6);
      check("sat_255_plus_5", {24'd0, value_cnt}, 32'd255);
      check("sat_sb_empty", exp_q.size(), 0);

      // Asynchronous reset with coins queued, raw line high across release.
      coin_ready = 1'b0;
      insert(1'b1, 1'b0, 0, 6);
      insert(1'b0, 1'b1, 0, 6);
      check("prerst_head_c5", {31'd0, c_5}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_c_5", {31'd0, c_5}, 32'd0);
      check("arst_c_10", {31'd0, c_10}, 32'd0);
      check("arst_value", {24'd0, value_cnt}, 32'd0);
      check("arst_reject", {31'd0, coin_reject}, 32'd0);
      exp_q.delete();
      coin5_raw = 1'b1;
      cyc(3);
      r0 = rej_seen;
      rst = 1'b1;
      coin_ready = 1'b1;
      exp_q.push_back(COIN_5);
      cyc(10);
      coin5_raw = 1'b0;
      cyc(12);
      check("postrst_value", {24'd0, value_cnt}, 32'd1);
      check("postrst_sb_empty", exp_q.size(), 0);
      check("postrst_reject", rej_seen - r0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
